// File: rtl/lamp_fpu_sqrt_round_pack.sv
// Result-side consumer of the square-root unit: nearest-even rounding, LAMP 1/8/7 packing,
// and a small result FIFO with valid/ready so the producer never has to stall.
module lamp_fpu_sqrt_round_pack #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic                          s_res_i,
  input  logic [7:0]                    e_res_i,
  input  logic [11:0]                   f_res_i,
  input  logic                          isToRound_i,
  output logic [15:0]                   res_o,
  output logic                          inexact_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 17;

  // Capture register
  logic        cap_v;
  logic        cap_s;
  logic [7:0]  cap_e;
  logic [11:0] cap_f;
  logic        cap_r;

  // Rounding and packing
  logic          g_bit;
  logic          r_bit;
  logic          s_bit;
  logic          up;
  logic          carry;
  logic [8:0]    exp9;
  logic [7:0]    exp_r;
  logic [6:0]    frac_r;
  logic [EW-1:0] entry;

  // FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;
  logic          full;
  logic          do_push;
  logic          drop;
  logic [CW-1:0] count_nxt;

  // Round to nearest-even; a carry out of the 8-bit significand bumps the exponent
  always_comb begin
    g_bit  = cap_f[2];
    r_bit  = cap_f[1];
    s_bit  = cap_f[0];
    up     = g_bit & (r_bit | s_bit | cap_f[3]);
    carry  = up & (&cap_f[10:3]);
    frac_r = 7'(cap_f[9:3] + 7'(up));
    exp9   = {1'b0, cap_e} + 9'(carry);
    exp_r  = exp9[7:0];
    if (exp9 >= 9'h0FF) begin
      exp_r  = 8'hFF;
      frac_r = 7'd0;
    end
    if (cap_r) begin
      entry = {cap_s, exp_r, frac_r, g_bit | r_bit | s_bit};
    end else begin
      entry = {cap_s, cap_e, cap_f[11:5], 1'b0};
    end
  end

  always_comb begin
    pop       = valid_o & ready_i;
    full      = (count_o == CW'(FIFO_DEPTH));
    do_push   = cap_v & (~full | pop);
    drop      = cap_v & full & ~pop;
    count_nxt = CW'(count_o + CW'(do_push) - CW'(pop));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_v      <= 1'b0;
      cap_s      <= 1'b0;
      cap_e      <= 8'd0;
      cap_f      <= 12'd0;
      cap_r      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      cap_v <= valid_i;
      if (valid_i) begin
        cap_s <= s_res_i;
        cap_e <= e_res_i;
        cap_f <= f_res_i;
        cap_r <= isToRound_i;
      end
      if (do_push) begin
        mem[wr_ptr] <= entry;
        wr_ptr      <= PW'(wr_ptr + PW'(1));
      end
      if (pop) begin
        rd_ptr <= PW'(rd_ptr + PW'(1));
      end
      count_o <= count_nxt;
      valid_o <= (count_nxt != '0);
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Head entry straight from storage; no input reaches res_o combinationally
  assign {res_o, inexact_o} = mem[rd_ptr];

endmodule

// File: tb/tb_lamp_fpu_sqrt_round_pack.sv
// Scoreboard bench for lamp_fpu_sqrt_round_pack: directed rounding/packing vectors,
// backpressure, full-FIFO streaming, mid-stream reset and randomized traffic.
module tb_lamp_fpu_sqrt_round_pack;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          s_res_i = 1'b0;
  logic [7:0]    e_res_i = 8'd0;
  logic [11:0]   f_res_i = 12'd0;
  logic          isToRound_i = 1'b0;
  logic [15:0]   res_o;
  logic          inexact_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  lamp_fpu_sqrt_round_pack #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .s_res_i(s_res_i), .e_res_i(e_res_i),
    .f_res_i(f_res_i), .isToRound_i(isToRound_i), .res_o(res_o), .inexact_o(inexact_o),
    .valid_o(valid_o), .ready_i(ready_i), .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  logic [16:0] exp_q[$];
  bit          cap_pend = 1'b0;
  logic [16:0] cap_val = '0;
  bit          m_ovf = 1'b0;
  bit          after_rst = 1'b1;
  logic [16:0] iss_exp = '0;

  // Reference: integer rounding of the 11-bit significand with 3 extra bits
  function automatic logic [16:0] ref_model(bit s, int e, int f, bit r);
    int sig, q, rem, ex, fr;
    if (!r) return {s, 8'(e), 7'(f >> 5), 1'b0};
    sig = f & 'h7FF;
    q   = sig >> 3;
    rem = sig & 7;
    if (rem > 4 || (rem == 4 && (q % 2) == 1)) q++;
    ex = e;
    if (q >= 256) begin
      q = q >> 1;
      ex++;
    end
    fr = q % 128;
    if (ex >= 255) begin
      ex = 255;
      fr = 0;
    end
    return {s, 8'(ex), 7'(fr), rem != 0};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor + model: compare the state after the last edge, then predict the next edge
  always @(negedge clk) begin
    int sz;
    bit m_pop;
    if (!done) begin
      sz = exp_q.size();
      chk("count", 32'(count_o), 32'(sz));
      chk("valid", 32'(valid_o), 32'(sz > 0));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      if (after_rst) begin
        chk("reset_res", 32'({res_o, inexact_o}), 32'd0);
      end else if (valid_o && sz > 0) begin
        chk("head", 32'({res_o, inexact_o}), 32'(exp_q[0]));
      end
      if (rst) begin
        exp_q.delete();
        cap_pend  = 1'b0;
        m_ovf     = 1'b0;
        after_rst = 1'b1;
      end else begin
        after_rst = 1'b0;
        m_pop = (sz > 0) && ready_i;
        if (m_pop) void'(exp_q.pop_front());
        if (cap_pend) begin
          if (sz < int'(DEPTH) || m_pop) exp_q.push_back(cap_val);
          else m_ovf = 1'b1;
        end
        cap_pend = valid_i;
        cap_val  = iss_exp;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit s, logic [7:0] e, logic [11:0] f, bit r, logic [16:0] ex);
    valid_i = 1'b1;
    s_res_i = s;
    e_res_i = e;
    f_res_i = f;
    isToRound_i = r;
    iss_exp = ex;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic issue_rand();
    bit s, r;
    logic [7:0] e;
    logic [11:0] f;
    s = 1'($urandom);
    r = ($urandom % 4) != 0;
    e = ($urandom % 4 == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
    f = 12'($urandom);
    if (r) begin
      f[11] = 1'b0;
      if ($urandom % 4 != 0) f[10] = 1'b1;
      if ($urandom % 6 == 0) f[10:3] = 8'hFF;
    end
    issue(s, e, f, r, ref_model(s, int'(e), int'(f), r));
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    ready_i = 1'b1;
    tick();
    issue(1'b0, 8'h7F, 12'h404, 1'b1, {16'h3F80, 1'b1});
    issue(1'b0, 8'h7F, 12'h40C, 1'b1, {16'h3F82, 1'b1});
    issue(1'b0, 8'h7F, 12'h408, 1'b1, {16'h3F81, 1'b0});
    issue(1'b0, 8'h7F, 12'h7FC, 1'b1, {16'h4000, 1'b1});
    issue(1'b0, 8'hFE, 12'h7FC, 1'b1, {16'h7F80, 1'b1});
    issue(1'b0, 8'hFF, 12'h800, 1'b0, {16'h7FC0, 1'b0});
    issue(1'b1, 8'h00, 12'h000, 1'b0, {16'h8000, 1'b0});
    repeat (3) tick();
    // Backpressure: third result is dropped
    ready_i = 1'b0;
    repeat (3) issue_rand();
    repeat (3) tick();
    ready_i = 1'b1;
    repeat (4) tick();
    // Fill, then stream while full
    ready_i = 1'b0;
    repeat (3) issue_rand();
    ready_i = 1'b1;
    repeat (6) issue_rand();
    // Reset mid-stream with a coincident valid_i
    ready_i = 1'b0;
    issue_rand();
    rst = 1'b1;
    issue_rand();
    rst = 1'b0;
    ready_i = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 600; i++) begin
      ready_i = ($urandom % 3) != 0;
      if (i == 300) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else if ($urandom % 3 != 0) begin
        issue_rand();
      end else begin
        tick();
      end
    end
    ready_i = 1'b1;
    repeat (6) tick();
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lamp_fpu_sqrt_round_pack.md
# lamp_fpu_sqrt_round_pack

Result-side consumer of the square-root unit's output bundle (sign, exponent, 12-bit guard/round/sticky significand, round-enable, valid). It rounds the significand to nearest-even, handles mantissa carry and exponent overflow, and packs a 16-bit LAMP float (1/8/7). It buffers results in a small FIFO with a valid/ready handshake, because the square-root unit has no backpressure input.

## Interface
- FIFO_DEPTH, 2: result FIFO entries; power of two, at least 2.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  result bundle valid; one-cycle pulse per result, never stalled.
- s_res_i  in  1  result sign.
- e_res_i  in  8  result exponent (biased).
- f_res_i  in  12  significand, layout described under Operation.
- isToRound_i  in  1  1 = normal result, round it; 0 = special value (zero/inf/NaN), pass it through.
- res_o  out  16  packed result {sign, exp[7:0], frac[6:0]} at FIFO head.
- inexact_o  out  1  inexact flag of the head entry.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  downstream accepts the head entry when valid_o && ready_i.
- count_o  out  log2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky; a result was dropped because the FIFO was full. Cleared only by rst.

## Operation
- Stage 1 is the capture register. When valid_i=1 it latches s, e, f and isToRound, and sets cap_v=1. Otherwise cap_v=0.
- Significand layout for round path (isToRound=1): [11] zero headroom, [10] hidden bit, [9:3] fraction, [2] guard G, [1] round R, [0] sticky S.
- Rounding, combinational from the capture register:
  - lsb = f[3].
  - up = G & (R | S | lsb).
  - m[8:0] = f[10:3] + up.
  - If m[8]=1: frac = 0 and exp = e+1. Otherwise frac = m[6:0] and exp = e.
  - If exp reaches 8'hFF: output infinity, frac = 0.
  - inexact = G | R | S.
- Pass-through path (isToRound=0):
  - frac = f[11:5]; special encodings carry their fraction left-aligned with 5 zero LSBs.
  - exp = e, sign = s, inexact = 0. No arithmetic is applied.
- Push: cap_v=1 writes {packed result, inexact} into the FIFO at the next edge.
- Pop: valid_o && ready_i.
- Full FIFO:
  - Push with no pop in the same cycle: the entry is dropped, overflow_o is set, count is unchanged.
  - Push and pop in the same cycle: both are performed, count is unchanged, nothing is dropped.
- Empty FIFO: pop is impossible because valid_o=0. Push into an empty FIFO appears at the head on the next cycle.
- Pointers wrap modulo FIFO_DEPTH. count_o tracks pushes minus pops; it never exceeds FIFO_DEPTH and never goes below 0.

## Timing
- Reset values: res_o=0, inexact_o=0, valid_o=0, count_o=0, overflow_o=0. cap_v=0 and both pointers are 0.
- rst mid-operation: all buffered and captured results are discarded at that edge. A valid_i in the same cycle as rst is ignored.
- Latency: valid_i sampled at edge N, FIFO write at edge N+1. With the FIFO empty, valid_o=1 and res_o are valid during the cycle after edge N+1, i.e. 2 cycles after valid_i.
- Throughput: one result per cycle in and out.
- res_o and inexact_o are driven from FIFO storage at the read pointer; there is no combinational path from any input to res_o.
- ready_i may toggle freely. The head entry holds stable while valid_o=1 and ready_i=0.

## Test plan
- Tie to even: e=8'h7F, f=12'h404, isToRound=1 -> res_o=16'h3F80, inexact_o=1, valid_o 2 cycles after valid_i.
- Round up: e=8'h7F, f=12'h40C -> res_o=16'h3F82, inexact_o=1. Exact case: f=12'h408 -> 16'h3F81, inexact_o=0.
- Mantissa carry and overflow:
  - e=8'h7F, f=12'h7FC -> 16'h4000, inexact_o=1.
  - e=8'hFE, f=12'h7FC -> 16'h7F80 (infinity), inexact_o=1.
- Pass-through:
  - isToRound=0, s=0, e=8'hFF, f=12'h800 -> 16'h7FC0, inexact_o=0.
  - s=1, e=0, f=0 -> 16'h8000.
- Backpressure, FIFO_DEPTH=2, ready_i=0:
  - valid_i pulses in 3 consecutive cycles -> count_o reaches 2, third result dropped, overflow_o=1 and stays 1.
  - Then set ready_i=1 -> the first two results drain in order, valid_o=0 afterwards.
- Simultaneous push/pop when full, and reset:
  - With count_o=2 and ready_i=1, stream results every cycle -> no drop, count_o stays 2, output order preserved.
  - Assert rst mid-stream -> all outputs return to 0 at the next edge, including overflow_o.
